lcd_host_seq: RTL and testbench

Command-side counterpart of the LCD image controller. Fetches a command script from a small command ROM and issues each command over the `cmd`/`cmd_valid`/`busy` handshake. Captures the controller's 64-byte image write-back on the IRB port into local storage, then computes a byte checksum for the host. Sits between the system host/test sequencer and the LCD controller.

---
 rtl/lcd_host_seq_pkg.sv | 34 +++
 rtl/lcd_host_seq_if.sv | 13 +
 rtl/lcd_host_seq_capture.sv | 33 +++
 rtl/lcd_host_seq.sv | 138 +++++++++++++
 tb/tb_lcd_host_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_host_seq_pkg.sv
// rtl/lcd_host_seq_pkg.sv - shared types and constants for the LCD host command sequencer
package lcd_host_pkg;

  localparam int IMG_N      = 64;
  localparam int ENTRY_LAST = 3;
  localparam int CMD_HI     = 2;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_AVG   = 3'd5,
    CMD_MIRX  = 3'd6,
    CMD_MIRY  = 3'd7
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_CPL,
    S_SUM,
    S_FIN
  } state_t;

  function automatic logic is_handshake(input state_t s);
    return (s == S_ISSUE) || (s == S_WAIT_ACK) || (s == S_WAIT_CPL);
  endfunction

endpackage

// File: rtl/lcd_host_seq_if.sv
// rtl/lcd_host_seq_if.sv - command handshake and image write-back bus to the LCD controller
interface lcd_host_seq_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       IRB_RW;
  logic [7:0] IRB_D;
  logic [5:0] IRB_A;

  modport master (output cmd, cmd_valid, input busy, done, IRB_RW, IRB_D, IRB_A);
  modport slave  (input cmd, cmd_valid, output busy, done, IRB_RW, IRB_D, IRB_A);
endinterface

// File: rtl/lcd_host_seq_capture.sv
// rtl/lcd_host_seq_capture.sv - 64x8 image capture store, one write port, host and sweep read ports
module lcd_capture_mem
  import lcd_host_pkg::*;
#(
  localparam int AW = $clog2(IMG_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] rd_a,
  output logic [7:0]    rd_q,
  input  logic [AW-1:0] sw_a,
  output logic [7:0]    sw_q
);

  logic [7:0] mem [IMG_N];

  // Capture storage is deliberately left out of reset so write-back survives it.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Host read port; a same-cycle write shows up only on the following read.
  always_ff @(posedge clk) begin
    if (!reset) rd_q <= 8'd0;
    else        rd_q <= mem[rd_a];
  end

  assign sw_q = mem[sw_a];

endmodule

// File: rtl/lcd_host_seq.sv
// rtl/lcd_host_seq.sv - command script sequencer and image checksum; watchdog under LCD_HOST_WDT_EN
module lcd_host_seq
  import lcd_host_pkg::*;
#(
  parameter int CROM_AW = 5
`ifdef LCD_HOST_WDT_EN
  , parameter int WDT_MAX = 1023
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               CROM_EN,
  output logic [CROM_AW-1:0] CROM_A,
  input  logic [3:0]         CROM_Q,
  lcd_host_seq_if.master     ctl,
  input  logic [5:0]         rd_a,
  output logic [7:0]         rd_q,
  output logic [13:0]        checksum,
  output logic               finished,
  output logic               err
);

  state_t      state, state_nx;
  logic [3:0]  entry_q;
  logic [5:0]  sum_a;
  logic [7:0]  sweep_q;
  logic        cmd_valid;
  logic        wdt_exp;
  logic        is_write;
  logic        last_addr;

  assign is_write  = (entry_q[CMD_HI:0] == CMD_WRITE);
  assign last_addr = (CROM_A == {CROM_AW{1'b1}});

  // Next-state and strobe decode; the watchdog overrides any handshake wait.
  always_comb begin
    state_nx  = state;
    CROM_EN   = 1'b0;
    cmd_valid = 1'b0;
    case (state)
      S_IDLE:     if (start) state_nx = S_FETCH;
      S_FETCH: begin
        CROM_EN  = 1'b1;
        state_nx = S_LATCH;
      end
      S_LATCH:    state_nx = S_ISSUE;
      S_ISSUE: begin
        if (!ctl.busy) begin
          cmd_valid = 1'b1;
          state_nx  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: if (ctl.busy) state_nx = S_WAIT_CPL;
      S_WAIT_CPL: begin
        if (is_write) begin
          if (ctl.done) state_nx = S_SUM;
        end else if (!ctl.busy) begin
          state_nx = (entry_q[ENTRY_LAST] || last_addr) ? S_FIN : S_FETCH;
        end
      end
      S_SUM:      if (sum_a == 6'(IMG_N - 1)) state_nx = S_FIN;
      S_FIN:      if (start) state_nx = S_FETCH;
      default:    state_nx = S_IDLE;
    endcase
    if (wdt_exp) begin
      state_nx  = S_FIN;
      cmd_valid = 1'b0;
    end
  end

  // State register, script pointer, latched entry and checksum sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      CROM_A   <= '0;
      entry_q  <= 4'd0;
      sum_a    <= 6'd0;
      checksum <= 14'd0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE || state == S_FIN) && start) begin
        CROM_A   <= '0;
        sum_a    <= 6'd0;
        checksum <= 14'd0;
      end
      if (state == S_LATCH) entry_q <= CROM_Q;
      if (state == S_WAIT_CPL && state_nx == S_FETCH) CROM_A <= CROM_A + 1'b1;
      if (state == S_SUM) begin
        checksum <= checksum + 14'(sweep_q);
        sum_a    <= sum_a + 1'b1;
      end
    end
  end

  assign ctl.cmd       = entry_q[CMD_HI:0];
  assign ctl.cmd_valid = cmd_valid;
  assign finished      = (state == S_FIN);

`ifdef LCD_HOST_WDT_EN
  logic [9:0] wdt_cnt;
  logic       err_q;

  assign wdt_exp = is_handshake(state) && (wdt_cnt == 10'(WDT_MAX));

  // Restart the count on every handshake-state entry, count while waiting in one.
  always_ff @(posedge clk) begin
    if (!reset)                                          wdt_cnt <= 10'd0;
    else if (is_handshake(state_nx) && state_nx != state) wdt_cnt <= 10'd0;
    else if (is_handshake(state))                         wdt_cnt <= wdt_cnt + 1'b1;
  end

  // Sticky expiry flag, cleared only by a restart from FIN.
  always_ff @(posedge clk) begin
    if (!reset)                       err_q <= 1'b0;
    else if (wdt_exp)                 err_q <= 1'b1;
    else if (state == S_FIN && start) err_q <= 1'b0;
  end

  assign err = err_q;
`else
  assign wdt_exp = 1'b0;
  assign err     = 1'b0;
`endif

  lcd_capture_mem u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (~ctl.IRB_RW),
    .wa    (ctl.IRB_A),
    .wd    (ctl.IRB_D),
    .rd_a  (rd_a),
    .rd_q  (rd_q),
    .sw_a  (sum_a),
    .sw_q  (sweep_q)
  );

endmodule

// File: tb/tb_lcd_host_seq.sv
// tb/tb_lcd_host_seq.sv - directed bench for lcd_host_seq with command ROM and controller models
module tb_lcd_host_seq;
  import lcd_host_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        CROM_EN;
  logic [4:0]  CROM_A;
  logic [3:0]  crom_q;
  logic [5:0]  rd_a;
  logic [7:0]  rd_q;
  logic [13:0] checksum;
  logic        finished;
  logic        err;
  logic [3:0]  rom [32];
  int          n_cmp;
  int          n_mis;

  lcd_host_seq_if ctl();

  lcd_host_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .CROM_EN  (CROM_EN),
    .CROM_A   (CROM_A),
    .CROM_Q   (crom_q),
    .ctl      (ctl),
    .rd_a     (rd_a),
    .rd_q     (rd_q),
    .checksum (checksum),
    .finished (finished),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Command ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (CROM_EN) crom_q <= rom[CROM_A];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Controller model: accept one command, hold busy, optionally write back the image.
  // wr: 0 none, 1 byte=i, 2 byte=255, 3 byte=255-i
  task automatic serve(input int blen, input int wr, input logic [2:0] exp_cmd,
                       input int exp_lat, input string tag);
    int n;
    int bad;
    int extra;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ctl.cmd_valid && n < 200);
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_cmd"}, 32'(ctl.cmd), 32'(exp_cmd));
    @(posedge clk); #1 ctl.busy = 1'b1;
    bad = 0;
    extra = 0;
    for (int i = 0; i < blen; i++) begin
      if (wr != 0 && i < 64) begin
        ctl.IRB_RW = 1'b0;
        ctl.IRB_A  = 6'(i);
        ctl.IRB_D  = (wr == 1) ? 8'(i) : (wr == 2) ? 8'hFF : 8'(255 - i);
      end else begin
        ctl.IRB_RW = 1'b1;
      end
      @(negedge clk);
      if (ctl.cmd !== exp_cmd) bad++;
      if (ctl.cmd_valid) extra++;
      @(posedge clk); #1;
    end
    ctl.IRB_RW = 1'b1;
    ctl.busy   = 1'b0;
    if (wr != 0) ctl.done = 1'b1;
    @(posedge clk); #1 ctl.done = 1'b0;
    check_eq({tag, "_hold"}, bad, 0);
    check_eq({tag, "_cv_once"}, extra, 0);
  endtask

  task automatic wait_fin(output int n);
    n = 0;
    while (!finished && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int cvs;
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b0;
    start = 1'b0;
    rd_a  = 6'd0;
    ctl.busy   = 1'b1;
    ctl.done   = 1'b0;
    ctl.IRB_RW = 1'b1;
    ctl.IRB_D  = 8'd0;
    ctl.IRB_A  = 6'd0;
    for (int i = 0; i < 32; i++) rom[i] = 4'h0;

    // Reset held three cycles with busy high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_crom_en", 32'(CROM_EN), 0);
    check_eq("rst_crom_a", 32'(CROM_A), 0);
    check_eq("rst_cmd", 32'(ctl.cmd), 0);
    check_eq("rst_cmd_valid", 32'(ctl.cmd_valid), 0);
    check_eq("rst_rd_q", 32'(rd_q), 0);
    check_eq("rst_checksum", 32'(checksum), 0);
    check_eq("rst_finished", 32'(finished), 0);
    check_eq("rst_err", 32'(err), 0);
    @(posedge clk); #1 reset = 1'b1; ctl.busy = 1'b0;
    cvs = 0;
    repeat (6) begin
      @(negedge clk);
      if (ctl.cmd_valid) cvs++;
    end
    check_eq("idle_no_cv", cvs, 0);

    // Script [UP, WRITE], image byte i at address i
    rom[0] = {1'b0, CMD_UP};
    rom[1] = {1'b0, CMD_WRITE};
    pulse_start();
    serve(5, 0, CMD_UP, 3, "up");
    serve(66, 1, CMD_WRITE, 3, "wr");
    wait_fin(n);
    check_eq("sum_cycles", n, 65);
    check_eq("sum_checksum", 32'(checksum), 2016);
    check_eq("sum_finished", 32'(finished), 1);
    check_eq("sum_err", 32'(err), 0);
    #1 rd_a = 6'd10;
    @(posedge clk); @(negedge clk);
    check_eq("rd_10", 32'(rd_q), 10);
    rd_a = 6'd63;
    @(posedge clk); @(negedge clk);
    check_eq("rd_63", 32'(rd_q), 63);
    // Same-cycle write and read of one address returns the old byte first
    rd_a = 6'd5; ctl.IRB_RW = 1'b0; ctl.IRB_A = 6'd5; ctl.IRB_D = 8'hAA;
    @(posedge clk); @(negedge clk);
    check_eq("rd_old", 32'(rd_q), 5);
    ctl.IRB_RW = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("rd_new", 32'(rd_q), 170);

    // Script [RIGHT, AVG|last, UP]: UP must never be fetched
    rom[0] = {1'b0, CMD_RIGHT};
    rom[1] = {1'b1, CMD_AVG};
    rom[2] = {1'b0, CMD_UP};
    pulse_start();
    check_eq("restart_finished", 32'(finished), 0);
    check_eq("restart_checksum", 32'(checksum), 0);
    serve(8, 0, CMD_RIGHT, 3, "right");
    serve(4, 0, CMD_AVG, 3, "avg");
    @(negedge clk);
    check_eq("last_finished", 32'(finished), 1);
    check_eq("last_checksum", 32'(checksum), 0);
    check_eq("last_crom_a", 32'(CROM_A), 1);

    // busy stuck high after issue
    rom[0] = {1'b0, CMD_LEFT};
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ctl.cmd_valid && n < 20);
    check_eq("stuck_lat", n, 3);
    @(posedge clk); #1 ctl.busy = 1'b1;
`ifdef LCD_HOST_WDT_EN
    n = 0;
    while (!finished && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check_eq("wdt_finished", 32'(finished), 1);
    check_eq("wdt_err", 32'(err), 1);
    check_eq("wdt_not_early", 32'(n >= 1000), 1);
`else
    cvs = 0;
    repeat (2000) begin
      @(negedge clk);
      if (finished) cvs++;
    end
    check_eq("hang_finished", cvs, 0);
    check_eq("hang_err", 32'(err), 0);
`endif
    #1 ctl.busy = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("rst2_err", 32'(err), 0);
    check_eq("rst2_finished", 32'(finished), 0);
    @(posedge clk); #1 reset = 1'b1;

    // Reset in the middle of SUM, then full re-run with all-0xFF image
    rom[0] = {1'b0, CMD_UP};
    rom[1] = {1'b0, CMD_WRITE};
    pulse_start();
    serve(3, 0, CMD_UP, 3, "r1up");
    serve(66, 3, CMD_WRITE, 3, "r1wr");
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("midsum_checksum", 32'(checksum), 0);
    check_eq("midsum_finished", 32'(finished), 0);
    check_eq("midsum_crom_a", 32'(CROM_A), 0);
    check_eq("midsum_cmd", 32'(ctl.cmd), 0);
    @(posedge clk); #1 reset = 1'b1;
    pulse_start();
    serve(3, 0, CMD_UP, 3, "r2up");
    serve(66, 2, CMD_WRITE, 3, "r2wr");
    wait_fin(n);
    check_eq("max_cycles", n, 65);
    check_eq("max_checksum", 32'(checksum), 16320);
    #1 rd_a = 6'd7;
    @(posedge clk); @(negedge clk);
    check_eq("rd_ff", 32'(rd_q), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
